// File: rtl/cpu_if_arb_pkg.sv
// Shared types and constants for the CPU register-access arbiter.
package cpu_if_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } arb_state_e;

  localparam logic [31:0] CPU_IF_TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        is_write;
    logic [31:2] addr;
    logic [31:0] wdata;
  } req_slot_t;

endpackage

// File: rtl/cpu_if_arb_rr.sv
// Combinational round-robin picker: first pending index after last_grant, wrapping.
module cpu_if_arb_rr
  import cpu_if_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IW-1:0]      last_grant,
  output logic               valid,
  output logic [IW-1:0]      index
);

  int unsigned cand;

  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_grant) + off) % NUM_REQ;
      if (!valid && pending[IW'(cand)]) begin
        valid = 1'b1;
        index = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/cpu_if_arbiter.sv
// Round-robin arbiter sharing one downstream CPU register port among NUM_REQ requesters.
// Optional WAIT-state timeout enabled by defining CPU_IF_ARB_TIMEOUT_EN.
module cpu_if_arbiter
  import cpu_if_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned IW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        r_cpu_if_read,
  input  logic [NUM_REQ-1:0]        r_cpu_if_write,
  input  logic [NUM_REQ-1:0][31:0]  r_cpu_if_write_data,
  input  logic [NUM_REQ-1:0][31:2]  r_cpu_if_address,
  output logic [31:0]               r_cpu_if_read_data,
  output logic [NUM_REQ-1:0]        r_cpu_if_access_complete,
  output logic                      m_cpu_if_read,
  output logic                      m_cpu_if_write,
  output logic [31:0]               m_cpu_if_write_data,
  output logic [31:2]               m_cpu_if_address,
  input  logic [31:0]               m_cpu_if_read_data,
  input  logic                      m_cpu_if_access_complete,
  output logic                      arb_busy,
  output logic [IW-1:0]             arb_grant_id,
  output logic                      timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 65536)
  begin : g_bad_params
    $error("cpu_if_arbiter: parameter out of range");
  end

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     pending_q, pending_d;
  req_slot_t              slot_q [NUM_REQ];
  req_slot_t              slot_d [NUM_REQ];
  logic [IW-1:0]          grant_q, grant_d;
  logic [IW-1:0]          last_grant_q, last_grant_d;
  logic                   m_read_q, m_read_d;
  logic                   m_write_q, m_write_d;
  logic [31:0]            m_wdata_q, m_wdata_d;
  logic [31:2]            m_addr_q, m_addr_d;
  logic [31:0]            r_rdata_q, r_rdata_d;
  logic [NUM_REQ-1:0]     r_cmpl_q, r_cmpl_d;
  logic                   pick_valid;
  logic [IW-1:0]          pick_index;
  logic                   done;
  logic [31:0]            done_data;

`ifdef CPU_IF_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0]            wait_cnt_q, wait_cnt_d;
  logic                   timeout_err_q, timeout_err_d;
`endif

  cpu_if_arb_rr #(.NUM_REQ(NUM_REQ)) u_rr (
    .pending    (pending_q),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .index      (pick_index)
  );

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    slot_d       = slot_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    m_read_d     = 1'b0;
    m_write_d    = 1'b0;
    m_wdata_d    = m_wdata_q;
    m_addr_d     = m_addr_q;
    r_rdata_d    = r_rdata_q;
    r_cmpl_d     = '0;
    done         = 1'b0;
    done_data    = m_cpu_if_read_data;
`ifdef CPU_IF_ARB_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = 1'b0;
`endif

    // A busy slot ignores new pulses; the slot being completed is still pending here.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pending_q[i] && (r_cpu_if_read[i] || r_cpu_if_write[i])) begin
        pending_d[i]       = 1'b1;
        slot_d[i].is_write = r_cpu_if_write[i];
        slot_d[i].addr     = r_cpu_if_address[i];
        slot_d[i].wdata    = r_cpu_if_write_data[i];
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_index;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        m_read_d  = !slot_q[grant_q].is_write;
        m_write_d = slot_q[grant_q].is_write;
        m_addr_d  = slot_q[grant_q].addr;
        m_wdata_d = slot_q[grant_q].wdata;
        state_d   = ST_WAIT;
`ifdef CPU_IF_ARB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (m_cpu_if_access_complete) begin
          done = 1'b1;
        end
`ifdef CPU_IF_ARB_TIMEOUT_EN
        else if (wait_cnt_q == TIMEOUT_LAST) begin
          done          = 1'b1;
          done_data     = CPU_IF_TIMEOUT_DATA;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (done) begin
      r_rdata_d          = done_data;
      r_cmpl_d[grant_q]  = 1'b1;
      pending_d[grant_q] = 1'b0;
      last_grant_d       = grant_q;
      state_d            = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      slot_q       <= '{default: '0};
      grant_q      <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
      m_wdata_q    <= '0;
      m_addr_q     <= '0;
      r_rdata_q    <= '0;
      r_cmpl_q     <= '0;
`ifdef CPU_IF_ARB_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      slot_q       <= slot_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_read_q     <= m_read_d;
      m_write_q    <= m_write_d;
      m_wdata_q    <= m_wdata_d;
      m_addr_q     <= m_addr_d;
      r_rdata_q    <= r_rdata_d;
      r_cmpl_q     <= r_cmpl_d;
`ifdef CPU_IF_ARB_TIMEOUT_EN
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign r_cpu_if_read_data       = r_rdata_q;
  assign r_cpu_if_access_complete = r_cmpl_q;
  assign m_cpu_if_read            = m_read_q;
  assign m_cpu_if_write           = m_write_q;
  assign m_cpu_if_write_data      = m_wdata_q;
  assign m_cpu_if_address         = m_addr_q;
  assign arb_busy                 = (state_q != ST_IDLE);
  assign arb_grant_id             = grant_q;
`ifdef CPU_IF_ARB_TIMEOUT_EN
  assign timeout_err              = timeout_err_q;
`else
  assign timeout_err              = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_if_arbiter.sv
// Self-checking bench for cpu_if_arbiter: directed vector table, corner sequences, random vs model.
module tb_cpu_if_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [N-1:0]         r_rd, r_wr;
  logic [N-1:0][31:0]   r_wd;
  logic [N-1:0][31:2]   r_ad;
  logic [31:0]          r_rdata;
  logic [N-1:0]         r_cmpl;
  logic                 m_rd, m_wr;
  logic [31:0]          m_wd;
  logic [31:2]          m_ad;
  logic [31:0]          m_rdata;
  logic                 m_cmpl;
  logic                 busy;
  logic [1:0]           gid;
  logic                 terr;

  int n_cmp = 0;
  int n_bad = 0;

  cpu_if_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk                      (clk),
    .reset_n                  (reset_n),
    .r_cpu_if_read            (r_rd),
    .r_cpu_if_write           (r_wr),
    .r_cpu_if_write_data      (r_wd),
    .r_cpu_if_address         (r_ad),
    .r_cpu_if_read_data       (r_rdata),
    .r_cpu_if_access_complete (r_cmpl),
    .m_cpu_if_read            (m_rd),
    .m_cpu_if_write           (m_wr),
    .m_cpu_if_write_data      (m_wd),
    .m_cpu_if_address         (m_ad),
    .m_cpu_if_read_data       (m_rdata),
    .m_cpu_if_access_complete (m_cmpl),
    .arb_busy                 (busy),
    .arb_grant_id             (gid),
    .timeout_err              (terr)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int          id;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    bit          exp_w;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_req(input int id, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wdata);
    r_rd[id] = rd;
    r_wr[id] = wr;
    r_ad[id] = addr[31:2];
    r_wd[id] = wdata;
    @(negedge clk);
    r_rd = '0;
    r_wr = '0;
  endtask

  // Waits for the downstream pulse, checks it, then answers after `delay` cycles.
  task automatic serve_one(input int id, input bit is_w, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int delay, output int waited);
    waited = 0;
    while (!(m_rd || m_wr) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!(m_rd || m_wr)) begin
      chk("pulse_seen", m_rd | m_wr, 1);
      return;
    end
    chk("grant_id", gid, id);
    chk("m_read", m_rd, !is_w);
    chk("m_write", m_wr, is_w);
    chk("m_addr", m_ad, addr[31:2]);
    if (is_w) chk("m_wdata", m_wd, wdata);
    @(negedge clk);
    chk("pulse_one_cycle", m_rd | m_wr, 0);
    chk("m_addr_hold", m_ad, addr[31:2]);
    repeat (delay) @(negedge clk);
    m_rdata = rdata;
    m_cmpl  = 1'b1;
    @(negedge clk);
    m_cmpl  = 1'b0;
    m_rdata = $urandom;
    chk("r_complete", r_cmpl, 64'(1) << id);
    chk("r_read_data", r_rdata, rdata);
    @(negedge clk);
    chk("complete_one_cycle", r_cmpl, 0);
    chk("read_data_hold", r_rdata, rdata);
  endtask

  // Reference model state for the random phase.
  logic [N-1:0] ph1, ph2, drv_rd, drv_wr, clr, cap;
  bit           mdl_isw [N];
  logic [31:2]  mdl_ad [N];
  logic [31:0]  mdl_wd [N];
  logic [31:0]  mdl_rd, drv_data;
  int           last_g, out_id, dly, exp_id, w, extra, cnt;
  bit           outst, cmpl_valid_drv, found;

  initial begin
    tbl[0] = '{2, 1'b1, 1'b0, 32'h1000_0040, 32'h0,         32'h1234_5678, 5, 1'b0};
    tbl[1] = '{0, 1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_0001, 32'h0,         0, 1'b1};
    tbl[2] = '{3, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h1111_2222, 1, 1'b1};
    tbl[3] = '{1, 1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0,         2, 1'b0};
    tbl[4] = '{3, 1'b1, 1'b0, 32'h8000_0004, 32'h0,         32'hA5A5_A5A5, 0, 1'b0};

    reset_n = 1'b0;
    r_rd = '0; r_wr = '0; r_wd = '0; r_ad = '0;
    m_rdata = '0; m_cmpl = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_r_complete", r_cmpl, 0);
    chk("rst_r_read_data", r_rdata, 0);
    chk("rst_m_pulse", {m_rd, m_wr}, 0);
    chk("rst_m_addr", m_ad, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", gid, 0);
    chk("rst_timeout", terr, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Table-driven single accesses, exact two-cycle issue latency.
    for (int t = 0; t < 5; t++) begin
      pulse_req(tbl[t].id, tbl[t].rd, tbl[t].wr, tbl[t].addr, tbl[t].wdata);
      serve_one(tbl[t].id, tbl[t].exp_w, tbl[t].addr, tbl[t].wdata, tbl[t].rdata,
                tbl[t].delay, w);
      chk("issue_latency", w, 2);
    end

    // Round-robin: last grant was 3, so all four writes go out 0,1,2,3.
    for (int i = 0; i < N; i++) begin
      r_wr[i] = 1'b1;
      r_ad[i] = 30'(32'h100 + i);
      r_wd[i] = 32'h5000_0000 + i;
    end
    @(negedge clk);
    r_wr = '0;
    for (int i = 0; i < N; i++)
      serve_one(i, 1'b1, 32'h400 + 4 * i, 32'h5000_0000 + i, 32'h7000_0000 + i, 1, w);
    r_wr[0] = 1'b1; r_ad[0] = 30'h11; r_wd[0] = 32'h0000_0A00;
    r_wr[3] = 1'b1; r_ad[3] = 30'h33; r_wd[3] = 32'h0000_0A03;
    @(negedge clk);
    r_wr = '0;
    serve_one(0, 1'b1, 32'h44, 32'h0000_0A00, 32'h0, 0, w);
    serve_one(3, 1'b1, 32'hCC, 32'h0000_0A03, 32'h0, 0, w);

    // Pulse while pending is dropped entirely.
    pulse_req(1, 1'b0, 1'b1, 32'h44, 32'h0000_AAAA);
    pulse_req(1, 1'b0, 1'b1, 32'h48, 32'h0000_BBBB);
    serve_one(1, 1'b1, 32'h44, 32'h0000_AAAA, 32'h9, 3, w);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_rd || m_wr || r_cmpl != 0 || busy) extra++;
    end
    chk("no_extra_access", extra, 0);

`ifdef CPU_IF_ARB_TIMEOUT_EN
    pulse_req(2, 1'b1, 1'b0, 32'h3000_0000, 32'h0);
    cnt = 0;
    while (!m_rd && cnt < 20) begin @(negedge clk); cnt++; end
    chk("to_pulse", m_rd, 1);
    cnt = 0;
    while (r_cmpl == 0 && cnt < 40) begin @(negedge clk); cnt++; end
    chk("to_latency", cnt, TO);
    chk("to_complete", r_cmpl, 4'b0100);
    chk("to_data", r_rdata, 32'hDEAD_BEEF);
    chk("to_err_pulse", terr, 1);
    m_rdata = 32'h5555_5555;
    m_cmpl  = 1'b1;
    @(negedge clk);
    m_cmpl  = 1'b0;
    chk("to_err_one_cycle", terr, 0);
    chk("to_late_ignored", r_cmpl, 0);
    chk("to_data_hold", r_rdata, 32'hDEAD_BEEF);
    chk("to_idle", busy, 0);
`endif

    // Reset in the middle of WAIT.
    pulse_req(3, 1'b1, 1'b0, 32'h10, 32'h0);
    cnt = 0;
    while (!m_rd && cnt < 20) begin @(negedge clk); cnt++; end
    chk("rw_pulse", m_rd, 1);
    repeat (2) @(negedge clk);
    chk("rw_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("rw_r_complete", r_cmpl, 0);
    chk("rw_r_read_data", r_rdata, 0);
    chk("rw_m_pulse", {m_rd, m_wr}, 0);
    chk("rw_m_addr", m_ad, 0);
    chk("rw_m_wdata", m_wd, 0);
    chk("rw_busy_low", busy, 0);
    chk("rw_grant", gid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    m_rdata = 32'h0BAD_0BAD;
    m_cmpl  = 1'b1;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      m_cmpl = 1'b0;
      if (r_cmpl != 0 || busy || m_rd || m_wr || r_rdata != 0) extra++;
    end
    chk("rw_nothing_after", extra, 0);

    // Random traffic against the model.
    ph1 = '0; ph2 = '0; drv_rd = '0; drv_wr = '0;
    last_g = N - 1; mdl_rd = '0; outst = 0; cmpl_valid_drv = 0; out_id = 0; dly = 0;
    drv_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      m_cmpl = 1'b0;
      clr = '0;
      if (cmpl_valid_drv) begin
        chk("rnd_complete", r_cmpl, 64'(1) << out_id);
        chk("rnd_rdata", r_rdata, drv_data);
        mdl_rd = drv_data;
        clr[out_id] = 1'b1;
        last_g = out_id;
        outst = 0;
      end else begin
        chk("rnd_no_complete", r_cmpl, 0);
        chk("rnd_rdata_hold", r_rdata, mdl_rd);
      end
      chk("rnd_timeout_err", terr, 0);
      if (m_rd || m_wr) begin
        found = 0;
        exp_id = 0;
        for (int o = 1; o <= N; o++) begin
          if (!found && ph2[(last_g + o) % N]) begin
            found = 1;
            exp_id = (last_g + o) % N;
          end
        end
        if (!found) chk("rnd_unexpected_issue", m_rd | m_wr, 0);
        chk("rnd_single_outstanding", outst, 0);
        chk("rnd_grant", gid, exp_id);
        chk("rnd_type", {m_rd, m_wr}, mdl_isw[exp_id] ? 2'b01 : 2'b10);
        chk("rnd_addr", m_ad, mdl_ad[exp_id]);
        if (mdl_isw[exp_id]) chk("rnd_wdata", m_wd, mdl_wd[exp_id]);
        outst = 1;
        out_id = exp_id;
        dly = $urandom_range(0, 6);
      end
      if (outst) chk("rnd_busy", busy, 1);
      cap = (drv_rd | drv_wr) & ~ph1;
      for (int i = 0; i < N; i++) begin
        if (cap[i]) begin
          mdl_isw[i] = drv_wr[i];
          mdl_ad[i]  = r_ad[i];
          mdl_wd[i]  = r_wd[i];
        end
      end
      ph2 = ph1;
      ph1 = (ph1 & ~clr) | cap;

      cmpl_valid_drv = 0;
      if (outst) begin
        if (dly == 0) begin
          drv_data = $urandom;
          m_rdata = drv_data;
          m_cmpl = 1'b1;
          cmpl_valid_drv = 1;
        end else begin
          dly--;
        end
      end else if ($urandom_range(0, 19) == 0) begin
        m_rdata = $urandom;
        m_cmpl = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        r_rd[i] = (cyc < 2500) && ($urandom_range(0, 5) == 0);
        r_wr[i] = (cyc < 2500) && ($urandom_range(0, 5) == 0);
        r_ad[i] = 30'($urandom);
        r_wd[i] = $urandom;
      end
      drv_rd = r_rd;
      drv_wr = r_wr;
    end
    chk("drain_idle", busy, 0);
    chk("drain_no_outstanding", outst, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
